// File: rtl/synth_param_bank.sv
// synth_param_bank
// Parameter register bank for the synthesizer voice. It holds NUM_OSC
// oscillator slots and NUM_ENV envelope slots, plus the global octave.
// Fields are written from the switches on a load edge. A key edge can nudge
// the addressed field by one, or move the global octave by one.
// Every stored field is kept masked to its own width. This means the
// flattened outputs are already zero-extended.
module synth_param_bank #(
    parameter int NUM_OSC     = 2,
    parameter int NUM_ENV     = 1,
    parameter int OCT_MIN     = 0,
    parameter int OCT_MAX     = 6,
    parameter int OCT_DEFAULT = 4
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [17:0]                 SW,
    input  logic                        load,
    input  logic                        key_on,
    input  logic [15:0]                 key_code,
    output logic [2:0]                  global_octave,
    output logic [NUM_OSC*9*11-1:0]     osc_params,
    output logic [NUM_ENV*7*11-1:0]     env_params,
    output logic [10:0]                 rd_data,
    output logic                        param_changed,
    output logic [6:0]                  changed_addr,
    output logic                        addr_err
);

    localparam int OSC_NP = 9;
    localparam int ENV_NP = 7;
    localparam int FW     = 11;

    localparam logic [15:0] KEY_PGUP   = 16'hE07D;
    localparam logic [15:0] KEY_PGDN   = 16'hE07A;
    localparam logic [15:0] KEY_OCT_UP = 16'hE075;
    localparam logic [15:0] KEY_OCT_DN = 16'hE072;

    // Bit width of each oscillator field.
    function automatic logic [3:0] osc_width(input logic [3:0] p);
        case (p)
            4'd0:    osc_width = 4'd3;   // wave
            4'd1:    osc_width = 4'd2;   // unison
            4'd2:    osc_width = 4'd7;   // detune
            4'd3:    osc_width = 4'd8;   // finetune
            4'd4:    osc_width = 4'd5;   // semitone
            4'd5:    osc_width = 4'd3;   // octave
            4'd6:    osc_width = 4'd7;   // panning
            4'd7:    osc_width = 4'd7;   // volume
            4'd8:    osc_width = 4'd2;   // output
            default: osc_width = 4'd0;
        endcase
    endfunction

    // Bit width of each envelope field.
    function automatic logic [3:0] env_width(input logic [3:0] p);
        case (p)
            4'd0:    env_width = 4'd11;  // attack
            4'd1:    env_width = 4'd11;  // decay
            4'd2:    env_width = 4'd7;   // sustain
            4'd3:    env_width = 4'd11;  // release
            4'd4:    env_width = 4'd4;   // target
            4'd5:    env_width = 4'd4;   // param
            4'd6:    env_width = 4'd7;   // amount
            default: env_width = 4'd0;
        endcase
    endfunction

    // Power-on value of each oscillator field.
    function automatic logic [10:0] osc_reset(input logic [3:0] p);
        case (p)
            4'd0:    osc_reset = 11'd0;
            4'd1:    osc_reset = 11'd0;
            4'd2:    osc_reset = 11'd50;
            4'd3:    osc_reset = 11'd101;
            4'd4:    osc_reset = 11'd13;
            4'd5:    osc_reset = 11'd4;
            4'd6:    osc_reset = 11'd51;
            4'd7:    osc_reset = 11'd101;
            4'd8:    osc_reset = 11'd1;
            default: osc_reset = 11'd0;
        endcase
    endfunction

    // Power-on value of each envelope field.
    function automatic logic [10:0] env_reset(input logic [3:0] p);
        case (p)
            4'd0:    env_reset = 11'd4;
            4'd1:    env_reset = 11'd4;
            4'd2:    env_reset = 11'd15;
            4'd3:    env_reset = 11'd4;
            4'd4:    env_reset = 11'd0;
            4'd5:    env_reset = 11'd0;
            4'd6:    env_reset = 11'd101;
            default: env_reset = 11'd0;
        endcase
    endfunction

    // All-ones mask for a field of width w. The same value is the field's
    // saturation ceiling.
    function automatic logic [10:0] field_mask(input logic [3:0] w);
        logic [11:0] m;
        m = (12'd1 << w) - 12'd1;
        field_mask = m[10:0];
    endfunction

    // Storage
    logic [10:0] osc_r [NUM_OSC][OSC_NP];
    logic [10:0] env_r [NUM_ENV][ENV_NP];

    // Edge detection. The arm flops stay clear until the input has been seen
    // low. This stops a level that is already high at reset release from
    // counting as an edge.
    logic load_q_r;
    logic key_q_r;
    logic load_arm_r;
    logic key_arm_r;

    logic        load_ev_s;
    logic        key_ev_s;
    logic        nudge_up_s;
    logic        nudge_dn_s;
    logic        oct_up_s;
    logic        oct_dn_s;
    logic [2:0]  mod_s;
    logic [3:0]  par_s;
    logic [10:0] val_s;

    logic [NUM_OSC*OSC_NP-1:0] osc_hit_s;
    logic [NUM_ENV*ENV_NP-1:0] env_hit_s;
    logic                      hit_any_s;
    logic [10:0]               cur_val_s;
    logic [10:0]               cur_max_s;
    logic [10:0]               new_val_s;
    logic                      wr_en_s;
    logic                      changed_s;
    logic                      addr_err_s;
    logic [2:0]                oct_next_s;

    assign mod_s = SW[17:15];
    assign par_s = SW[14:11];
    assign val_s = SW[10:0];

    assign load_ev_s  = load & ~load_q_r & load_arm_r;
    assign key_ev_s   = key_on & ~key_q_r & key_arm_r;
    assign nudge_up_s = key_ev_s & (key_code == KEY_PGUP);
    assign nudge_dn_s = key_ev_s & (key_code == KEY_PGDN);
    assign oct_up_s   = key_ev_s & (key_code == KEY_OCT_UP);
    assign oct_dn_s   = key_ev_s & (key_code == KEY_OCT_DN);

    // Delay load/key_on one cycle; arm each input once it has been low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            load_q_r   <= 1'b0;
            key_q_r    <= 1'b0;
            load_arm_r <= 1'b0;
            key_arm_r  <= 1'b0;
        end else begin
            load_q_r   <= load;
            key_q_r    <= key_on;
            load_arm_r <= load_arm_r | ~load;
            key_arm_r  <= key_arm_r | ~key_on;
        end
    end

    // Decode the switch address into one-hot slot hits. Also select that
    // field's current value and ceiling. An unmapped address selects zeros.
    always_comb begin
        osc_hit_s = '0;
        env_hit_s = '0;
        hit_any_s = 1'b0;
        cur_val_s = 11'd0;
        cur_max_s = 11'd0;
        for (int o = 0; o < NUM_OSC; o++) begin
            for (int p = 0; p < OSC_NP; p++) begin
                osc_hit_s[o*OSC_NP+p] = (mod_s == 3'(o)) && (par_s == 4'(p));
                hit_any_s = hit_any_s | osc_hit_s[o*OSC_NP+p];
                cur_val_s = cur_val_s | ({FW{osc_hit_s[o*OSC_NP+p]}} & osc_r[o][p]);
                cur_max_s = cur_max_s |
                            ({FW{osc_hit_s[o*OSC_NP+p]}} & field_mask(osc_width(4'(p))));
            end
        end
        for (int e = 0; e < NUM_ENV; e++) begin
            for (int p = 0; p < ENV_NP; p++) begin
                env_hit_s[e*ENV_NP+p] = (mod_s == 3'(NUM_OSC + e)) && (par_s == 4'(p));
                hit_any_s = hit_any_s | env_hit_s[e*ENV_NP+p];
                cur_val_s = cur_val_s | ({FW{env_hit_s[e*ENV_NP+p]}} & env_r[e][p]);
                cur_max_s = cur_max_s |
                            ({FW{env_hit_s[e*ENV_NP+p]}} & field_mask(env_width(4'(p))));
            end
        end
    end

    // Compute the candidate value. A load beats a nudge in the same cycle,
    // and nudges saturate at 0 and at the field ceiling.
    always_comb begin
        new_val_s = cur_val_s;
        if (load_ev_s) begin
            new_val_s = val_s & cur_max_s;
        end else if (nudge_up_s) begin
            if (cur_val_s == cur_max_s) begin
                new_val_s = cur_val_s;
            end else begin
                new_val_s = cur_val_s + 11'd1;
            end
        end else if (nudge_dn_s) begin
            if (cur_val_s == 11'd0) begin
                new_val_s = cur_val_s;
            end else begin
                new_val_s = cur_val_s - 11'd1;
            end
        end else begin
            new_val_s = cur_val_s;
        end
    end

    assign wr_en_s    = hit_any_s & (load_ev_s | nudge_up_s | nudge_dn_s);
    assign changed_s  = wr_en_s & (new_val_s != cur_val_s);
    assign addr_err_s = load_ev_s & ~hit_any_s;

    // Next global octave, saturating at the configured bounds.
    always_comb begin
        oct_next_s = global_octave;
        if (oct_up_s) begin
            if (global_octave < 3'(OCT_MAX)) begin
                oct_next_s = global_octave + 3'd1;
            end else begin
                oct_next_s = global_octave;
            end
        end else if (oct_dn_s) begin
            if (global_octave > 3'(OCT_MIN)) begin
                oct_next_s = global_octave - 3'd1;
            end else begin
                oct_next_s = global_octave;
            end
        end else begin
            oct_next_s = global_octave;
        end
    end

    // Oscillator field storage: load/nudge writes to the addressed field.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int o = 0; o < NUM_OSC; o++) begin
                for (int p = 0; p < OSC_NP; p++) begin
                    osc_r[o][p] <= osc_reset(4'(p));
                end
            end
        end else begin
            for (int o = 0; o < NUM_OSC; o++) begin
                for (int p = 0; p < OSC_NP; p++) begin
                    if (wr_en_s && osc_hit_s[o*OSC_NP+p]) begin
                        osc_r[o][p] <= new_val_s;
                    end else begin
                        osc_r[o][p] <= osc_r[o][p];
                    end
                end
            end
        end
    end

    // Envelope field storage: load/nudge writes to the addressed field.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int e = 0; e < NUM_ENV; e++) begin
                for (int p = 0; p < ENV_NP; p++) begin
                    env_r[e][p] <= env_reset(4'(p));
                end
            end
        end else begin
            for (int e = 0; e < NUM_ENV; e++) begin
                for (int p = 0; p < ENV_NP; p++) begin
                    if (wr_en_s && env_hit_s[e*ENV_NP+p]) begin
                        env_r[e][p] <= new_val_s;
                    end else begin
                        env_r[e][p] <= env_r[e][p];
                    end
                end
            end
        end
    end

    // Global octave register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            global_octave <= 3'(OCT_DEFAULT);
        end else begin
            global_octave <= oct_next_s;
        end
    end

    // Status outputs: readback of the pre-edge value, change pulse and
    // address, and the unmapped-load pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data       <= 11'd0;
            param_changed <= 1'b0;
            changed_addr  <= 7'd0;
            addr_err      <= 1'b0;
        end else begin
            rd_data       <= cur_val_s;
            param_changed <= changed_s;
            if (changed_s) begin
                changed_addr <= {mod_s, par_s};
            end else begin
                changed_addr <= changed_addr;
            end
            addr_err      <= addr_err_s;
        end
    end

    // Flatten the slot storage onto the output buses.
    for (genvar go = 0; go < NUM_OSC; go++) begin : g_osc_out
        for (genvar gp = 0; gp < OSC_NP; gp++) begin : g_par
            assign osc_params[(go*OSC_NP+gp)*FW +: FW] = osc_r[go][gp];
        end
    end

    for (genvar ge = 0; ge < NUM_ENV; ge++) begin : g_env_out
        for (genvar gp = 0; gp < ENV_NP; gp++) begin : g_par
            assign env_params[(ge*ENV_NP+gp)*FW +: FW] = env_r[ge][gp];
        end
    end

endmodule

// File: tb/tb_synth_param_bank.sv
// Testbench for synth_param_bank. It runs a directed vector table, a
// hand-written reset-during-hold sequence, and random traffic. A behavioural
// model checks every output on every clock.
module tb_synth_param_bank;

    localparam int NOSC = 2;
    localparam int NENV = 1;

    logic                  clock;
    logic                  resetn;
    logic [17:0]           SW;
    logic                  load;
    logic                  key_on;
    logic [15:0]           key_code;
    logic [2:0]            global_octave;
    logic [NOSC*99-1:0]    osc_params;
    logic [NENV*77-1:0]    env_params;
    logic [10:0]           rd_data;
    logic                  param_changed;
    logic [6:0]            changed_addr;
    logic                  addr_err;

    synth_param_bank #(
        .NUM_OSC(NOSC), .NUM_ENV(NENV), .OCT_MIN(0), .OCT_MAX(6), .OCT_DEFAULT(4)
    ) dut (
        .clock(clock), .resetn(resetn), .SW(SW), .load(load), .key_on(key_on),
        .key_code(key_code), .global_octave(global_octave), .osc_params(osc_params),
        .env_params(env_params), .rd_data(rd_data), .param_changed(param_changed),
        .changed_addr(changed_addr), .addr_err(addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int OSC_W [9] = '{3, 2, 7, 8, 5, 3, 7, 7, 2};
    int ENV_W [7] = '{11, 11, 7, 11, 4, 4, 7};
    int OSC_R [9] = '{0, 0, 50, 101, 13, 4, 51, 101, 1};
    int ENV_R [7] = '{4, 4, 15, 4, 0, 0, 101};

    // Reference model state
    int osc_m [NOSC][9];
    int env_m [NENV][7];
    int oct_m;
    bit m_load_q, m_key_q, m_load_seen_low, m_key_seen_low;
    int exp_rd, exp_pc, exp_ae, exp_ca;

    typedef struct {
        logic [17:0] sw;
        logic        ld;
        logic        ky;
        logic [15:0] code;
        int          f;     // expected field at SW address after the edge, -1 = skip
        int          pc;
        int          ae;
        int          ca;
        int          oct;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [17:0] mk_sw(int m, int p, int v);
        return {3'(m), 4'(p), 11'(v)};
    endfunction

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_wide(string nm, logic [395:0] act, logic [395:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_valid(int m, int p);
        return (m < NOSC && p < 9) || (m >= NOSC && m < NOSC + NENV && p < 7);
    endfunction

    function automatic int m_get(int m, int p);
        if (m < NOSC) return osc_m[m][p];
        return env_m[m-NOSC][p];
    endfunction

    function automatic int m_width(int m, int p);
        if (m < NOSC) return OSC_W[p];
        return ENV_W[p];
    endfunction

    task automatic m_set(int m, int p, int v);
        if (m < NOSC) osc_m[m][p] = v;
        else env_m[m-NOSC][p] = v;
    endtask

    task automatic model_reset();
        for (int o = 0; o < NOSC; o++) for (int p = 0; p < 9; p++) osc_m[o][p] = OSC_R[p];
        for (int e = 0; e < NENV; e++) for (int p = 0; p < 7; p++) env_m[e][p] = ENV_R[p];
        oct_m = 4;
        m_load_q = 0; m_key_q = 0; m_load_seen_low = 0; m_key_seen_low = 0;
        exp_rd = 0; exp_pc = 0; exp_ae = 0; exp_ca = 0;
    endtask

    // Advance the model by one clock edge, using the inputs as they are just
    // before that edge.
    task automatic model_step();
        int m, p, v, cur, mx, nv;
        bit le, ke, vld;
        m = int'(SW[17:15]); p = int'(SW[14:11]); v = int'(SW[10:0]);
        le = load && !m_load_q && m_load_seen_low;
        ke = key_on && !m_key_q && m_key_seen_low;
        vld = m_valid(m, p);
        cur = vld ? m_get(m, p) : 0;
        mx  = vld ? (1 << m_width(m, p)) - 1 : 0;
        exp_rd = cur;
        exp_pc = 0;
        exp_ae = (le && !vld) ? 1 : 0;
        nv = cur;
        if (vld && le) nv = v & mx;
        else if (vld && ke && key_code == 16'hE07D) nv = (cur < mx) ? cur + 1 : cur;
        else if (vld && ke && key_code == 16'hE07A) nv = (cur > 0) ? cur - 1 : cur;
        if (nv != cur) begin
            m_set(m, p, nv);
            exp_pc = 1;
            exp_ca = m * 16 + p;
        end
        if (ke && key_code == 16'hE075 && oct_m < 6) oct_m++;
        else if (ke && key_code == 16'hE072 && oct_m > 0) oct_m--;
        m_load_q = load; m_key_q = key_on;
        if (!load) m_load_seen_low = 1;
        if (!key_on) m_key_seen_low = 1;
    endtask

    task automatic model_compare();
        logic [NOSC*99-1:0] eo;
        logic [NENV*77-1:0] ee;
        for (int o = 0; o < NOSC; o++)
            for (int p = 0; p < 9; p++) eo[(o*9+p)*11 +: 11] = 11'(osc_m[o][p]);
        for (int e = 0; e < NENV; e++)
            for (int p = 0; p < 7; p++) ee[(e*7+p)*11 +: 11] = 11'(env_m[e][p]);
        chk_wide("osc_params", 396'(osc_params), 396'(eo));
        chk_wide("env_params", 396'(env_params), 396'(ee));
        chk("global_octave", int'(global_octave), oct_m);
        chk("rd_data", int'(rd_data), exp_rd);
        chk("param_changed", int'(param_changed), exp_pc);
        chk("changed_addr", int'(changed_addr), exp_ca);
        chk("addr_err", int'(addr_err), exp_ae);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        model_compare();
    endtask

    function automatic int get_act(int m, int p);
        if (m < NOSC && p < 9) return int'(osc_params[(m*9+p)*11 +: 11]);
        if (m >= NOSC && m < NOSC + NENV && p < 7) return int'(env_params[((m-NOSC)*7+p)*11 +: 11]);
        return -1;
    endfunction

    task automatic row(int m, int p, int v, int ld, int ky, int code,
                       int f, int pc, int ae, int ca, int oct);
        vec_t r;
        r.sw = mk_sw(m, p, v); r.ld = 1'(ld); r.ky = 1'(ky); r.code = 16'(code);
        r.f = f; r.pc = pc; r.ae = ae; r.ca = ca; r.oct = oct;
        tbl.push_back(r);
    endtask

    initial begin
        int o;
        resetn = 1'b0; SW = 18'd0; load = 1'b0; key_on = 1'b0; key_code = 16'd0;
        model_reset();

        // Build the directed table
        row(1, 2, 2047, 1, 0, 0, 127, 1, 0, 'h12, 4);
        row(1, 2, 2047, 0, 0, 0, 127, 0, 0, 'h12, 4);
        row(1, 2, 2047, 1, 0, 0, 127, 0, 0, 'h12, 4);
        row(1, 2, 5,    1, 0, 0, 127, 0, 0, 'h12, 4);
        row(1, 2, 5,    0, 0, 0, 127, 0, 0, 'h12, 4);
        row(1, 2, 5,    1, 0, 0, 5,   1, 0, 'h12, 4);
        for (int i = 0; i < 10; i++) row(1, 2, 9, 1, 0, 0, 5, 0, 0, 'h12, 4);
        row(1, 2, 9, 0, 0, 0, 5, 0, 0, 'h12, 4);
        row(0, 1, 3, 0, 0, 0, 0, 0, 0, 'h12, 4);
        row(0, 1, 3, 1, 0, 0, 3, 1, 0, 'h01, 4);
        for (int i = 0; i < 2; i++) begin
            row(0, 1, 3, 0, 1, 'hE07D, 3, 0, 0, 'h01, 4);
            row(0, 1, 3, 0, 0, 0,      3, 0, 0, 'h01, 4);
        end
        for (int i = 0; i < 4; i++) begin
            int v;
            v = (2 - i > 0) ? 2 - i : 0;
            row(0, 1, 3, 0, 1, 'hE07A, v, (i < 3) ? 1 : 0, 0, 'h01, 4);
            row(0, 1, 3, 0, 0, 0,      v, 0, 0, 'h01, 4);
        end
        for (int i = 0; i < 5; i++) begin
            o = (5 + i < 6) ? 5 + i : 6;
            row(0, 1, 3, 0, 1, 'hE075, 0, 0, 0, 'h01, o);
            row(0, 1, 3, 0, 0, 0,      0, 0, 0, 'h01, o);
        end
        for (int i = 0; i < 8; i++) begin
            o = (5 - i > 0) ? 5 - i : 0;
            row(0, 1, 3, 0, 1, 'hE072, 0, 0, 0, 'h01, o);
            row(0, 1, 3, 0, 0, 0,      0, 0, 0, 'h01, o);
        end
        row(0, 1, 3, 0, 1, 'h001C, 0, 0, 0, 'h01, 0);
        row(0, 1, 3, 0, 0, 0,      0, 0, 0, 'h01, 0);
        row(7, 0, 5, 1, 0, 0, -1, 0, 1, 'h01, 0);
        row(7, 0, 5, 0, 0, 0, -1, 0, 0, 'h01, 0);
        row(0, 9, 5, 1, 0, 0, -1, 0, 1, 'h01, 0);
        row(0, 9, 5, 0, 0, 0, -1, 0, 0, 'h01, 0);
        row(2, 7, 5, 1, 0, 0, -1, 0, 1, 'h01, 0);
        row(2, 7, 5, 0, 0, 0, -1, 0, 0, 'h01, 0);
        row(2, 6, 0, 1, 0, 0, 0, 1, 0, 'h26, 0);
        row(2, 6, 0, 0, 0, 0, 0, 0, 0, 'h26, 0);
        row(1, 3, 20, 1, 1, 'hE07D, 20, 1, 0, 'h13, 0);
        row(1, 3, 20, 0, 0, 0,      20, 0, 0, 'h13, 0);
        row(1, 4, 7, 1, 1, 'hE075, 7, 1, 0, 'h14, 1);
        row(1, 4, 7, 0, 0, 0,      7, 0, 0, 'h14, 1);
        row(5, 0, 0, 0, 1, 'hE07D, -1, 0, 0, 'h14, 1);
        row(5, 0, 0, 0, 0, 0,      -1, 0, 0, 'h14, 1);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        model_compare();
        chk("reset_octave", int'(global_octave), 4);
        chk("reset_rd", int'(rd_data), 0);
        @(negedge clock);
        resetn = 1'b1;

        // Read back every mapped field
        for (int m = 0; m < NOSC + NENV; m++) begin
            for (int p = 0; p < ((m < NOSC) ? 9 : 7); p++) begin
                SW = mk_sw(m, p, 0);
                tick();
                chk($sformatf("rd_reset_%0d_%0d", m, p), int'(rd_data),
                    (m < NOSC) ? OSC_R[p] : ENV_R[p]);
            end
        end

        // Directed table
        foreach (tbl[i]) begin
            SW = tbl[i].sw; load = tbl[i].ld; key_on = tbl[i].ky; key_code = tbl[i].code;
            tick();
            if (tbl[i].f >= 0)
                chk($sformatf("vec%0d_field", i),
                    get_act(int'(tbl[i].sw[17:15]), int'(tbl[i].sw[14:11])), tbl[i].f);
            chk($sformatf("vec%0d_pc", i), int'(param_changed), tbl[i].pc);
            chk($sformatf("vec%0d_ae", i), int'(addr_err), tbl[i].ae);
            chk($sformatf("vec%0d_ca", i), int'(changed_addr), tbl[i].ca);
            chk($sformatf("vec%0d_oct", i), int'(global_octave), tbl[i].oct);
        end

        // Reset asserted while load is held; a level held through reset
        // must not fire until it has been seen low.
        SW = mk_sw(1, 5, 2); load = 1'b1; key_on = 1'b0; key_code = 16'd0;
        tick();
        chk("hold_write", get_act(1, 5), 2);
        tick();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        model_compare();
        chk("midreset_field", get_act(1, 5), 4);
        chk("midreset_ca", int'(changed_addr), 0);
        @(negedge clock);
        resetn = 1'b1;
        SW = mk_sw(1, 5, 3);
        repeat (3) tick();
        chk("post_reset_no_fire", get_act(1, 5), 4);
        chk("post_reset_no_pulse", int'(param_changed), 0);
        load = 1'b0;
        tick();
        load = 1'b1;
        tick();
        chk("post_reset_write", get_act(1, 5), 3);
        chk("post_reset_pulse", int'(param_changed), 1);
        load = 1'b0;
        tick();

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            int m, p, v;
            int sel;
            if ($urandom_range(0, 3) != 0) m = $urandom_range(0, NOSC + NENV - 1);
            else m = $urandom_range(0, 7);
            p = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 8) : $urandom_range(0, 15);
            v = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2047) : $urandom_range(0, 3);
            SW = mk_sw(m, p, v);
            load = 1'($urandom_range(0, 2) == 0);
            key_on = 1'($urandom_range(0, 1) == 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1:    key_code = 16'hE07D;
                2:       key_code = 16'hE07A;
                3:       key_code = 16'hE075;
                4:       key_code = 16'hE072;
                default: key_code = 16'h001C;
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
